// File: rtl/shift_pkg.sv
// Shared types and constants for the serial word deserializer.
//   state_e        : receive FSM states (IDLE, SHIFT, PARITY)
//   DIR_MSB_FIRST  : msb_first value meaning the first bit is the word MSB
//   DIR_LSB_FIRST  : msb_first value meaning the first bit is the word LSB
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

endpackage

// File: rtl/deser_out_slot.sv
// One-entry valid/ready holding register for assembled words.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load         : a completed word is offered this cycle
//   load_word    : the completed word
//   load_perr    : parity error flag travelling with load_word
//   word_ready   : downstream accepts word_out this cycle
//   word_out     : held word
//   word_valid   : word_out holds an undelivered word
//   parity_err   : parity flag of word_out
//   overflow     : 1-cycle pulse, an offered word was dropped because the slot was full
module deser_out_slot #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    input  logic             load_perr,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             parity_err,
    output logic             overflow
);

    logic [WIDTH-1:0] word_q;
    logic             valid_q;
    logic             perr_q;
    logic             ovf_q;
    logic             slot_free;

    // The slot can take a new word if empty or if its current word leaves this cycle.
    assign slot_free = !valid_q || word_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (load && slot_free) begin
                word_q  <= load_word;
                perr_q  <= load_perr;
                valid_q <= 1'b1;
            end else if (load) begin
                // Held word has priority; the new one is lost.
                ovf_q <= 1'b1;
            end else if (valid_q && word_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign parity_err = perr_q;
    assign overflow   = ovf_q;

endmodule

// File: rtl/serial_word_deser.sv
// Deserializer for MSB-first or LSB-first serial streams: collects WIDTH qualified bits into a
// word and hands it to a one-entry valid/ready output slot.
// Optional feature: define SERIAL_WORD_DESER_PARITY_EN to expect one even-parity bit after the
// data bits; the word then completes on the parity bit and parity_err reports a mismatch.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bit_in       : serial data bit
//   bit_valid    : bit_in qualified this cycle
//   msb_first    : direction, sampled on the first bit of each word
//   flush        : discard the partially collected word (wins over bit_valid)
//   word_out     : assembled word
//   word_valid   : word_out holds an undelivered word
//   word_ready   : downstream accepts word_out
//   busy         : partial word in progress
//   overflow     : 1-cycle pulse, completed word dropped
//   parity_err   : parity mismatch of word_out (0 without the parity feature)
module serial_word_deser
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             msb_first,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overflow,
    output logic             parity_err
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic             dir_q;

    logic             dir_eff;
    logic [WIDTH-1:0] sr_shift;
    logic             last_data;
    logic             load;
    logic [WIDTH-1:0] load_word;
    logic             load_perr;

    always_comb begin
        // Direction is taken live on the first bit, then held for the rest of the word.
        dir_eff   = (state_q == IDLE) ? msb_first : dir_q;
        sr_shift  = (dir_eff == DIR_MSB_FIRST) ? {sr_q[WIDTH-2:0], bit_in}
                                               : {bit_in, sr_q[WIDTH-1:1]};
        last_data = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SERIAL_WORD_DESER_PARITY_EN
        load      = bit_valid && !flush && (state_q == PARITY);
        load_word = sr_q;
        load_perr = ^{sr_q, bit_in};
`else
        load      = bit_valid && !flush && (state_q == SHIFT) && last_data;
        load_word = sr_shift;
        load_perr = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            if (reset) begin
                dir_q <= DIR_LSB_FIRST;
            end
        end else if (bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    state_q <= SHIFT;
                    cnt_q   <= CNT_W'(1);
                    sr_q    <= sr_shift;
                    dir_q   <= msb_first;
                end
                SHIFT: begin
                    if (last_data) begin
`ifdef SERIAL_WORD_DESER_PARITY_EN
                        state_q <= PARITY;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        sr_q    <= sr_shift;
`else
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        sr_q    <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        sr_q  <= sr_shift;
                    end
                end
                PARITY: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    sr_q    <= '0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    sr_q    <= '0;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);

    deser_out_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_word  (load_word),
        .load_perr  (load_perr),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .parity_err (parity_err),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_serial_word_deser.sv
module tb_serial_word_deser;

    localparam int unsigned WIDTH = 4;
`ifdef SERIAL_WORD_DESER_PARITY_EN
    localparam int unsigned NBITS = WIDTH + 1;
`else
    localparam int unsigned NBITS = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             bit_in = 1'b0;
    logic             bit_valid = 1'b0;
    logic             msb_first = 1'b1;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic             busy;
    logic             overflow;
    logic             parity_err;

    int tests = 0;
    int fails = 0;

    serial_word_deser #(
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .msb_first  (msb_first),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected deliveries, each {parity_err, word}.
    logic [WIDTH:0] exp_q[$];
    logic           m_bits[$];
    logic           m_dir = 1'b1;
    logic           m_full = 1'b0;
    logic           m_ovf = 1'b0;

    function automatic logic [WIDTH:0] assemble(input logic dir);
        int unsigned w = 0;
        int unsigned ones = 0;
        for (int i = 0; i < NBITS; i++) begin
            if (m_bits[i]) ones++;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (m_bits[i]) begin
                if (dir) w += 1 << (WIDTH - 1 - i);
                else     w += 1 << i;
            end
        end
        // Odd count over data + parity means a parity error; without parity it is always 0.
        return {(NBITS > WIDTH) ? 1'(ones % 2) : 1'b0, WIDTH'(w)};
    endfunction

    always @(posedge clk) begin
        logic           done;
        logic [WIDTH:0] w;
        done = 1'b0;
        w    = '0;
        if (reset) begin
            exp_q.delete();
            m_bits.delete();
            m_full = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            if (flush) begin
                m_bits.delete();
            end else if (bit_valid) begin
                if (m_bits.size() == 0) m_dir = msb_first;
                m_bits.push_back(bit_in);
                if (m_bits.size() == NBITS) begin
                    w    = assemble(m_dir);
                    done = 1'b1;
                    m_bits.delete();
                end
            end
            m_ovf = 1'b0;
            if (done) begin
                if (!m_full || word_ready) begin
                    exp_q.push_back(w);
                    m_full = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_full && word_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (!reset) begin
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {31'd0, word_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_word", 32'(word_out), 32'(e[WIDTH-1:0]));
                    check("sb_parity_err", {31'd0, parity_err}, {31'd0, e[WIDTH]});
                end
            end
            if (overflow || m_ovf) begin
                check("sb_overflow", {31'd0, overflow}, {31'd0, m_ovf});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input logic dir);
        bit_in    = b;
        msb_first = dir;
        bit_valid = 1'b1;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
    endtask

    // seq[WIDTH-1] goes first; a correct even-parity bit follows when parity is enabled,
    // inverted when bad_par is set.
    task automatic send_word(input logic [WIDTH-1:0] seq, input logic dir, input int gap,
                             input logic bad_par);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            send_bit(seq[i], dir);
            if (i == WIDTH - 1) check("busy_mid_word", {31'd0, busy}, 32'd1);
            if (i > 0) idle(gap);
        end
`ifdef SERIAL_WORD_DESER_PARITY_EN
        idle(gap);
        send_bit((^seq) ^ bad_par, dir);
`else
        if (bad_par) idle(0);
`endif
    endtask

    initial begin
        idle(2);
        check("reset_word_out", 32'(word_out), 32'd0);
        check("reset_word_valid", {31'd0, word_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_parity_err", {31'd0, parity_err}, 32'd0);
        reset = 1'b0;
        idle(1);

        // 1: MSB-first 1,0,1,1
        word_ready = 1'b1;
        send_word(4'b1011, 1'b1, 0, 1'b0);
        check("t1_word", 32'(word_out), 32'hB);
        check("t1_valid", {31'd0, word_valid}, 32'd1);
        check("t1_busy_done", {31'd0, busy}, 32'd0);
        idle(1);
        check("t1_valid_drop", {31'd0, word_valid}, 32'd0);

        // 2: LSB-first 1,0,1,1
        send_word(4'b1011, 1'b0, 0, 1'b0);
        check("t2_word", 32'(word_out), 32'hD);
        idle(2);

        // 3: overflow with full slot
        word_ready = 1'b0;
        send_word(4'hA, 1'b1, 0, 1'b0);
        send_word(4'h5, 1'b1, 0, 1'b0);
        check("t3_overflow", {31'd0, overflow}, 32'd1);
        check("t3_word_held", 32'(word_out), 32'hA);
        idle(1);
        check("t3_overflow_pulse", {31'd0, overflow}, 32'd0);
        word_ready = 1'b1;
        idle(1);
        check("t3_drained", {31'd0, word_valid}, 32'd0);

        // 4: flush partial word, then word with gaps
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b1);
        flush     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        idle(1);
        flush     = 1'b0;
        bit_valid = 1'b0;
        check("t4_flush_busy", {31'd0, busy}, 32'd0);
        send_word(4'b0110, 1'b1, 2, 1'b0);
        check("t4_word", 32'(word_out), 32'h6);
        idle(2);

        // 5: reset mid-word
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_valid", {31'd0, word_valid}, 32'd0);
        check("t5_word", 32'(word_out), 32'd0);
        send_word(4'b1100, 1'b1, 0, 1'b0);
        check("t5_next_word", 32'(word_out), 32'hC);
        idle(2);

`ifdef SERIAL_WORD_DESER_PARITY_EN
        // 6: parity good / bad
        send_word(4'b1011, 1'b1, 0, 1'b0);
        check("t6_perr_ok", {31'd0, parity_err}, 32'd0);
        send_word(4'b1011, 1'b1, 0, 1'b1);
        check("t6_perr_bad", {31'd0, parity_err}, 32'd1);
        check("t6_word", 32'(word_out), 32'hB);
        idle(2);
`endif

        // Randomized traffic, including mid-word direction changes and back-pressure.
        for (int c = 0; c < 600; c++) begin
            bit_valid  = ($urandom_range(0, 2) != 0);
            bit_in     = 1'($urandom_range(0, 1));
            msb_first  = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 39) == 0);
            word_ready = 1'($urandom_range(0, 1));
            idle(1);
        end
        bit_valid  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b1;
        idle(4);
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_valid", {31'd0, word_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
